// File: rtl/drink_vend_ctrl.sv
// Drink vending controller: edge-detected coin entry, a dispense handshake with a timeout,
// and a one-coin-at-a-time change/refund handshake. All outputs come straight from flops.
module drink_vend_ctrl #(
    parameter int PRICE    = 3,
    parameter int DISP_TMO = 50
) (
    input  logic       CP,
    input  logic       Rst_sync,
    input  logic [1:0] X,
    input  logic       Cancel,
    input  logic       Disp_done,
    input  logic       Chg_ack,
    output logic       Disp_req,
    output logic       Chg_req,
    output logic [2:0] Credit,
    output logic [2:0] cur_state,
    output logic       Err
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        CREDIT   = 3'b001,
        DISPENSE = 3'b010,
        CHANGE   = 3'b011,
        REFUND   = 3'b100
    } state_t;

    localparam int         TW         = (DISP_TMO > 1) ? $clog2(DISP_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(DISP_TMO - 1);
    localparam logic [3:0] PRICE_W    = 4'(PRICE);
    localparam logic [2:0] PRICE_C    = 3'(PRICE);
    localparam logic [3:0] CREDIT_MAX = 4'd4;

    state_t        state_q, state_d;
    logic [1:0]    x_q;
    logic          x_held_rst_q;
    logic [2:0]    credit_q, credit_d;
    logic          disp_req_q, disp_req_d;
    logic          chg_req_q, chg_req_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          coin_evt;
    logic [1:0]    coin_add;
    logic          coin_bad;
    logic [3:0]    credit_sum;
    logic [2:0]    credit_acc;

    // A button already pressed while reset was held must be released before it counts.
    assign coin_evt = (x_q == 2'b00) && (X != 2'b00) && !x_held_rst_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        coin_add   = 2'd0;
        coin_bad   = 1'b0;
        state_d    = state_q;
        credit_d   = credit_q;
        disp_req_d = 1'b0;
        chg_req_d  = 1'b0;
        err_d      = 1'b0;
        tmo_d      = '0;

        if (coin_evt) begin
            case (X)
                2'b01:   coin_add = 2'd1;
                2'b10:   coin_add = 2'd2;
                default: coin_bad = 1'b1;
            endcase
        end
        credit_sum = {1'b0, credit_q} + {2'b00, coin_add};
        if (coin_evt && credit_sum > CREDIT_MAX) begin
            coin_bad = 1'b1;
        end
        credit_acc = coin_bad ? credit_q : credit_sum[2:0];

        case (state_q)
            IDLE, CREDIT: begin
                // The coin is credited first; Cancel only matters if the total is still short.
                err_d    = coin_bad;
                credit_d = credit_acc;
                if ({1'b0, credit_acc} >= PRICE_W) begin
                    state_d    = DISPENSE;
                    disp_req_d = 1'b1;
                end else if (Cancel && credit_acc != 3'd0) begin
                    state_d   = REFUND;
                    chg_req_d = 1'b1;
                end else if (credit_acc != 3'd0) begin
                    state_d = CREDIT;
                end else begin
                    state_d = IDLE;
                end
            end
            DISPENSE: begin
                if (Disp_done) begin
                    credit_d  = credit_q - PRICE_C;
                    chg_req_d = (credit_q > PRICE_C);
                    state_d   = (credit_q > PRICE_C) ? CHANGE : IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    chg_req_d = (credit_q != 3'd0);
                    state_d   = REFUND;
                end else begin
                    tmo_d      = tmo_q + 1'b1;
                    disp_req_d = 1'b1;
                end
            end
            CHANGE, REFUND: begin
                if (chg_req_q && Chg_ack && credit_q != 3'd0) begin
                    credit_d = credit_q - 3'd1;
                end
                chg_req_d = (credit_d != 3'd0);
                if (credit_d == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Rst_sync) begin
            state_q      <= IDLE;
            x_q          <= 2'b00;
            x_held_rst_q <= (X != 2'b00);
            credit_q     <= 3'd0;
            disp_req_q   <= 1'b0;
            chg_req_q    <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= X;
            x_held_rst_q <= 1'b0;
            credit_q     <= credit_d;
            disp_req_q   <= disp_req_d;
            chg_req_q    <= chg_req_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign Disp_req  = disp_req_q;
    assign Chg_req   = chg_req_q;
    assign Credit    = credit_q;
    assign cur_state = state_q;
    assign Err       = err_q;

endmodule
